// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder/subtractor built around a single 8-bit CLA stage.
// Latency: NBYTES cycles from accept to out_valid, fixed and data-independent.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in HOLD until out_ready.

// 8-bit carry-lookahead adder; every carry is a flat sum-of-products of g/p/cin.
// c7 (carry into bit 7) is exposed so the caller can form signed overflow.
module CLA8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       term;
  logic       acc;

  // Lookahead carries: c[i+1] = p[i:0]&cin | OR_k( g[k] & p[i:k+1] )
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = term & p[j];
      end
      acc = term;
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int j = k + 1; j <= i; j++) begin
          term = term & p[j];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
  assign c7   = c[7];

endmodule

module wide_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] b_eff;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_c7;

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  // Subtract is A + ~B + 1; the +1 comes from the carry register seeded with sub.
  assign b_eff = sub_q ? ~b_byte : b_byte;

  CLA8bit u_cla (
    .a    (a_byte),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout),
    .c7   (add_c7)
  );

  // Next-state and datapath update for the IDLE -> RUN -> HOLD sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[i*8 +: 8] = add_sum;
          end
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Top byte: carry-out is the final flag; overflow is c_in(msb) ^ c_out(msb).
          cout_d  = add_cout;
          ovf_d   = add_c7 ^ add_cout;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with NBYTES=4.
// Latency: expects out_valid exactly 4 cycles after the accept edge.
// Backpressure: exercises HOLD with out_ready low and requests pending.
module tb_wide_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Present a request at a negedge, let it be accepted, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv; sub = ~sv;
  endtask

  // Count rising edges until out_valid, capped so a dead DUT cannot hang the run.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); cnt++; @(negedge clk);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset result: got %h expected 0", result); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset flags: got cout=%b ovf=%b expected 0 0", cout, ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] tr [4];
    logic         tc [4];
    logic         to [4];
    int cnt;
    ta = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    tb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000};
    tr = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000};
    tc = '{1'b0, 1'b1, 1'b0, 1'b1};
    to = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add[%0d] in_ready before: got %b expected 1", i, in_ready); end
      start_op(ta[i], tb[i], 1'b0);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL add[%0d] run handshake: got in_ready=%b out_valid=%b expected 0 0", i, in_ready, out_valid); end
      wait_done(cnt);
      checks++; if (cnt != NB) begin errors++; $display("FAIL add[%0d] latency: got %0d expected %0d", i, cnt, NB); end
      checks++; if (result !== tr[i]) begin errors++; $display("FAIL add[%0d] result: got %h expected %h", i, result, tr[i]); end
      checks++; if (cout !== tc[i]) begin errors++; $display("FAIL add[%0d] cout: got %b expected %b", i, cout, tc[i]); end
      checks++; if (ovf !== to[i]) begin errors++; $display("FAIL add[%0d] ovf: got %b expected %b", i, ovf, to[i]); end
      release_result();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add[%0d] release: got out_valid=%b in_ready=%b expected 0 1", i, out_valid, in_ready); end
      checks++; if (result !== tr[i]) begin errors++; $display("FAIL add[%0d] idle hold: got %h expected %h", i, result, tr[i]); end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] tr [3];
    logic         tc [3];
    logic         to [3];
    int cnt;
    ta = '{32'h80000000, 32'h00000005, 32'h12345678};
    tb = '{32'h00000001, 32'h00000007, 32'h12345678};
    tr = '{32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000000};
    tc = '{1'b1, 1'b0, 1'b1};
    to = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      wait_done(cnt);
      checks++; if (cnt != NB) begin errors++; $display("FAIL sub[%0d] latency: got %0d expected %0d", i, cnt, NB); end
      checks++; if (result !== tr[i]) begin errors++; $display("FAIL sub[%0d] result: got %h expected %h", i, result, tr[i]); end
      checks++; if (cout !== tc[i]) begin errors++; $display("FAIL sub[%0d] cout: got %b expected %b", i, cout, tc[i]); end
      checks++; if (ovf !== to[i]) begin errors++; $display("FAIL sub[%0d] ovf: got %b expected %b", i, ovf, to[i]); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    start_op(32'h11111111, 32'h22222222, 1'b0);
    wait_done(cnt);
    checks++; if (cnt != NB || result !== 32'h33333333) begin errors++; $display("FAIL bp first op: got lat=%0d result=%h expected %0d 33333333", cnt, result, NB); end
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; sub = k[0];
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] handshake: got out_valid=%b in_ready=%b expected 1 0", k, out_valid, in_ready); end
      checks++; if (result !== 32'h33333333) begin errors++; $display("FAIL bp hold[%0d] result: got %h expected 33333333", k, result); end
    end
    a = 32'h00000010; b = 32'h00000020; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp to idle: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
    checks++; if (result !== 32'h33333333) begin errors++; $display("FAIL bp idle result: got %h expected 33333333", result); end
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp pending accept: got in_ready=%b expected 0", in_ready); end
    in_valid = 1'b0;
    wait_done(cnt);
    checks++; if (cnt != NB || result !== 32'h00000030) begin errors++; $display("FAIL bp second op: got lat=%0d result=%h expected %0d 00000030", cnt, result, NB); end
    release_result();
  endtask

  task automatic test_async_reset();
    int cnt;
    logic seen;
    start_op(32'h01020304, 32'h01010101, 1'b0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++; if (result[15:0] !== 16'h0405) begin errors++; $display("FAIL arst partial bytes: got %h expected 0405", result[15:0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (result !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL arst outputs: got result=%h cout=%b ovf=%b expected 0 0 0", result, cout, ovf); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst aborted op: got out_valid pulse=%b expected 0", seen); end
    start_op(32'h00000002, 32'h00000003, 1'b0);
    wait_done(cnt);
    checks++; if (cnt != NB || result !== 32'h00000005) begin errors++; $display("FAIL arst fresh op: got lat=%0d result=%h expected %0d 00000005", cnt, result, NB); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL arst fresh flags: got cout=%b ovf=%b expected 0 0", cout, ovf); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
